// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Round-robin burst arbiter sharing the single write port of the asynchronous
// FIFO among NUM_REQ producers in the FIFO write-clock domain. One requester
// owns the port at a time for up to MAX_BURST words. The write port is
// stalled by myWfull, so no write is ever issued into a full FIFO.
//
// Parameters
//   MyDSIZE   : data width (matches FIFO data width)
//   NUM_REQ   : number of requesters, 2..8
//   MAX_BURST : maximum words per grant, 1..15
//
// Ports
//   myClk      in  : FIFO write clock
//   myRst      in  : asynchronous active-high reset
//   myReqValid in  : per-requester word available
//   myReqData  in  : per-requester data, requester i at [i*MyDSIZE +: MyDSIZE]
//   myReqReady out : per-requester accept strobe (combinational)
//   myGrant    out : registered one-hot owner, zero when idle
//   myWreq     out : FIFO write request (combinational)
//   myWdata    out : FIFO write data (combinational)
//   myWfull    in  : FIFO full flag, write domain
//   myWordCnt  out : words written since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
    parameter int MyDSIZE   = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       myClk,
    input  logic                       myRst,
    input  logic [NUM_REQ-1:0]         myReqValid,
    input  logic [NUM_REQ*MyDSIZE-1:0] myReqData,
    output logic [NUM_REQ-1:0]         myReqReady,
    output logic [NUM_REQ-1:0]         myGrant,
    output logic                       myWreq,
    output logic [MyDSIZE-1:0]         myWdata,
    input  logic                       myWfull,
    output logic [15:0]                myWordCnt
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDXW-1:0] LAST_IDX_RST = IDXW'(NUM_REQ - 1);
    localparam logic [3:0]      BURST_LAST   = 4'(MAX_BURST - 1);
    localparam logic [IDXW:0]   NUM_REQ_W    = (IDXW + 1)'(NUM_REQ);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arbState_t;

    arbState_t          state;
    arbState_t          stateNext;
    logic [IDXW-1:0]    lastIdx;
    logic [IDXW-1:0]    lastIdxNext;
    logic [3:0]         burstCnt;
    logic [3:0]         burstCntNext;
    logic [NUM_REQ-1:0] grantNext;
    logic [15:0]        wordCntNext;

    logic [IDXW-1:0]    selIdx;
    logic               selFound;
    logic [IDXW:0]      candSum;
    logic [IDXW-1:0]    candSel;
    logic               ownerValid;
    logic               acc;

    // Round-robin search: first valid index strictly after lastIdx, wrapping.
    always_comb begin
        selIdx   = lastIdx;
        selFound = 1'b0;
        candSum  = '0;
        candSel  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            candSum = {1'b0, lastIdx} + (IDXW + 1)'(k);
            if (candSum >= NUM_REQ_W) begin
                candSel = IDXW'(candSum - NUM_REQ_W);
            end else begin
                candSel = candSum[IDXW-1:0];
            end
            if (!selFound && myReqValid[candSel]) begin
                selIdx   = candSel;
                selFound = 1'b1;
            end else begin
                selFound = selFound;
            end
        end
    end

    // In BURST the owner index is lastIdx, so no separate owner register exists.
    assign ownerValid = myReqValid[lastIdx];
    assign acc        = (state == BURST) && ownerValid && !myWfull;

    // Write-port and handshake outputs; gated by myWfull in the same cycle.
    always_comb begin
        myReqReady = '0;
        myWreq     = 1'b0;
        myWdata    = '0;
        if (state == BURST) begin
            myReqReady[lastIdx] = acc;
            myWreq              = acc;
            myWdata             = myReqData[lastIdx*MyDSIZE +: MyDSIZE];
        end else begin
            myWreq = 1'b0;
        end
    end

    // Next-state logic for the arbitration FSM and its counters.
    always_comb begin
        stateNext    = state;
        grantNext    = myGrant;
        lastIdxNext  = lastIdx;
        burstCntNext = burstCnt;
        wordCntNext  = myWordCnt;
        case (state)
            IDLE: begin
                if (selFound) begin
                    stateNext    = BURST;
                    grantNext    = {{(NUM_REQ-1){1'b0}}, 1'b1} << selIdx;
                    lastIdxNext  = selIdx;
                    burstCntNext = 4'd0;
                end else begin
                    grantNext = '0;
                end
            end
            BURST: begin
                if (acc) begin
                    wordCntNext  = myWordCnt + 16'd1;
                    burstCntNext = burstCnt + 4'd1;
                end else begin
                    wordCntNext  = myWordCnt;
                    burstCntNext = burstCnt;
                end
                // Withdrawal wins even when the count would have completed.
                if (!ownerValid || (acc && (burstCnt == BURST_LAST))) begin
                    stateNext    = IDLE;
                    grantNext    = '0;
                    burstCntNext = 4'd0;
                end else begin
                    stateNext = BURST;
                end
            end
            default: begin
                stateNext    = IDLE;
                grantNext    = '0;
                burstCntNext = 4'd0;
            end
        endcase
    end

    // State register; reset aborts any burst immediately.
    always_ff @(posedge myClk or posedge myRst) begin
        if (myRst) begin
            state     <= IDLE;
            myGrant   <= '0;
            lastIdx   <= LAST_IDX_RST;
            burstCnt  <= 4'd0;
            myWordCnt <= 16'd0;
        end else begin
            state     <= stateNext;
            myGrant   <= grantNext;
            lastIdx   <= lastIdxNext;
            burstCnt  <= burstCntNext;
            myWordCnt <= wordCntNext;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Self-checking bench for fifo_write_arbiter. Directed scenarios check the
// reset state, burst timing, round-robin order, full stall, early withdrawal,
// reset mid-burst and a depth-16 FIFO fill/drain. A randomized phase compares
// every cycle against a transaction-level reference model of the arbiter.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int MB = 4;

    logic              myClk = 1'b0;
    logic              myRst;
    logic [NR-1:0]     myReqValid;
    logic [NR*DW-1:0]  myReqData;
    logic [NR-1:0]     myReqReady;
    logic [NR-1:0]     myGrant;
    logic              myWreq;
    logic [DW-1:0]     myWdata;
    logic              myWfull;
    logic [15:0]       myWordCnt;

    int checks = 0;
    int fails  = 0;
    int prodCnt [NR];
    logic [DW-1:0] fifoQ [$];

    fifo_write_arbiter #(.MyDSIZE(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .myClk      (myClk),
        .myRst      (myRst),
        .myReqValid (myReqValid),
        .myReqData  (myReqData),
        .myReqReady (myReqReady),
        .myGrant    (myGrant),
        .myWreq     (myWreq),
        .myWdata    (myWdata),
        .myWfull    (myWfull),
        .myWordCnt  (myWordCnt)
    );

    always #5 myClk = ~myClk;

    // Producer i presents word i*16 + n + 1 where n is the words it has sent.
    task automatic drive_data();
        for (int i = 0; i < NR; i++) myReqData[i*DW +: DW] = DW'(i*16 + prodCnt[i] + 1);
    endtask

    // Clock one cycle, advance producers that handshook, return at negedge.
    task automatic advance();
        logic [NR-1:0] xfer;
        xfer = myReqReady & myReqValid;
        @(posedge myClk);
        for (int i = 0; i < NR; i++) if (xfer[i]) prodCnt[i]++;
        @(negedge myClk);
        drive_data();
    endtask

    task automatic do_reset();
        @(negedge myClk);
        myRst      = 1'b1;
        myReqValid = '0;
        myWfull    = 1'b0;
        for (int i = 0; i < NR; i++) prodCnt[i] = 0;
        drive_data();
        @(negedge myClk);
        @(negedge myClk);
        myRst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge myClk);
        myRst      = 1'b1;
        myReqValid = 4'b1111;
        myWfull    = 1'b0;
        for (int i = 0; i < NR; i++) prodCnt[i] = 0;
        drive_data();
        @(posedge myClk);
        #1;
        checks++; if (myGrant !== 4'b0000) begin fails++; $display("FAIL reset_grant: got %b want 0000", myGrant); end
        checks++; if (myReqReady !== 4'b0000) begin fails++; $display("FAIL reset_ready: got %b want 0000", myReqReady); end
        checks++; if (myWreq !== 1'b0) begin fails++; $display("FAIL reset_wreq: got %b want 0", myWreq); end
        checks++; if (myWdata !== 8'h00) begin fails++; $display("FAIL reset_wdata: got %h want 00", myWdata); end
        checks++; if (myWordCnt !== 16'd0) begin fails++; $display("FAIL reset_wordcnt: got %0d want 0", myWordCnt); end
        @(negedge myClk);
        myRst      = 1'b0;
        myReqValid = '0;
    endtask

    task automatic test_single_requester();
        logic       expW;
        logic [7:0] expD;
        do_reset();
        myReqValid = 4'b0001;
        for (int c = 0; c <= 10; c++) begin
            #1;
            expW = ((c >= 1) && (c <= 4)) || ((c >= 6) && (c <= 9));
            expD = expW ? ((c <= 4) ? 8'(c) : 8'(c - 1)) : 8'h00;
            checks++; if (myWreq !== expW) begin fails++; $display("FAIL single_wreq c%0d: got %b want %b", c, myWreq, expW); end
            checks++; if (myWdata !== expD) begin fails++; $display("FAIL single_wdata c%0d: got %0d want %0d", c, myWdata, expD); end
            checks++; if (myGrant !== (expW ? 4'b0001 : 4'b0000)) begin fails++; $display("FAIL single_grant c%0d: got %b want %b", c, myGrant, expW ? 4'b0001 : 4'b0000); end
            advance();
        end
        #1;
        checks++; if (myWordCnt !== 16'd8) begin fails++; $display("FAIL single_wordcnt: got %0d want 8", myWordCnt); end
    endtask

    task automatic test_round_robin();
        int b, req, w;
        logic [3:0] expG;
        logic [7:0] expD;
        do_reset();
        myReqValid = 4'b1111;
        for (int c = 0; c < 25; c++) begin
            #1;
            if ((c % 5) == 0) begin
                expG = 4'b0000;
                expD = 8'h00;
            end else begin
                b    = (c - 1) / 5;
                req  = b % 4;
                w    = (b / 4) * 4 + (c % 5) - 1;
                expG = 4'(1 << req);
                expD = 8'(req*16 + w + 1);
            end
            checks++; if (myGrant !== expG) begin fails++; $display("FAIL rr_grant c%0d: got %b want %b", c, myGrant, expG); end
            checks++; if (myWreq !== (expG != 4'b0000)) begin fails++; $display("FAIL rr_wreq c%0d: got %b want %b", c, myWreq, expG != 4'b0000); end
            checks++; if (myWdata !== expD) begin fails++; $display("FAIL rr_wdata c%0d: got %0d want %0d", c, myWdata, expD); end
            advance();
        end
    endtask

    task automatic test_full_stall();
        logic       expW;
        logic [3:0] expG;
        logic [7:0] expD;
        do_reset();
        myReqValid = 4'b0001;
        for (int c = 0; c <= 8; c++) begin
            myWfull = (c >= 3) && (c <= 5);
            #1;
            expW = (c == 1) || (c == 2) || (c == 6) || (c == 7);
            expG = ((c >= 1) && (c <= 7)) ? 4'b0001 : 4'b0000;
            expD = (c <= 2) ? 8'(c) : 8'(c - 3);
            checks++; if (myWreq !== expW) begin fails++; $display("FAIL stall_wreq c%0d: got %b want %b", c, myWreq, expW); end
            checks++; if (myReqReady !== (expW ? 4'b0001 : 4'b0000)) begin fails++; $display("FAIL stall_ready c%0d: got %b want %b", c, myReqReady, expW ? 4'b0001 : 4'b0000); end
            checks++; if (myGrant !== expG) begin fails++; $display("FAIL stall_grant c%0d: got %b want %b", c, myGrant, expG); end
            if (expW) begin
                checks++; if (myWdata !== expD) begin fails++; $display("FAIL stall_wdata c%0d: got %0d want %0d", c, myWdata, expD); end
            end
            advance();
        end
        myWfull = 1'b0;
        #1;
        checks++; if (myWordCnt !== 16'd4) begin fails++; $display("FAIL stall_wordcnt: got %0d want 4", myWordCnt); end
    endtask

    task automatic test_early_withdraw();
        logic [3:0] expG;
        logic       expW;
        logic [7:0] expD;
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            myReqValid = (c <= 2) ? 4'b1100 : 4'b1000;
            #1;
            case (c)
                1:       begin expG = 4'b0100; expW = 1'b1; expD = 8'd33; end
                2:       begin expG = 4'b0100; expW = 1'b1; expD = 8'd34; end
                3:       begin expG = 4'b0100; expW = 1'b0; expD = 8'd0;  end
                5:       begin expG = 4'b1000; expW = 1'b1; expD = 8'd49; end
                default: begin expG = 4'b0000; expW = 1'b0; expD = 8'd0;  end
            endcase
            checks++; if (myGrant !== expG) begin fails++; $display("FAIL withdraw_grant c%0d: got %b want %b", c, myGrant, expG); end
            checks++; if (myWreq !== expW) begin fails++; $display("FAIL withdraw_wreq c%0d: got %b want %b", c, myWreq, expW); end
            if (expW) begin
                checks++; if (myWdata !== expD) begin fails++; $display("FAIL withdraw_wdata c%0d: got %0d want %0d", c, myWdata, expD); end
            end
            advance();
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        myReqValid = 4'b0001;
        for (int c = 0; c < 3; c++) advance();
        #1;
        checks++; if (myWordCnt !== 16'd2) begin fails++; $display("FAIL midrst_precnt: got %0d want 2", myWordCnt); end
        checks++; if (myWreq !== 1'b1) begin fails++; $display("FAIL midrst_prewreq: got %b want 1", myWreq); end
        myRst = 1'b1;
        #1;
        checks++; if (myGrant !== 4'b0000) begin fails++; $display("FAIL midrst_grant: got %b want 0000", myGrant); end
        checks++; if (myReqReady !== 4'b0000) begin fails++; $display("FAIL midrst_ready: got %b want 0000", myReqReady); end
        checks++; if (myWreq !== 1'b0) begin fails++; $display("FAIL midrst_wreq: got %b want 0", myWreq); end
        checks++; if (myWdata !== 8'h00) begin fails++; $display("FAIL midrst_wdata: got %h want 00", myWdata); end
        checks++; if (myWordCnt !== 16'd0) begin fails++; $display("FAIL midrst_wordcnt: got %0d want 0", myWordCnt); end
        @(negedge myClk);
        @(negedge myClk);
        myRst      = 1'b0;
        myReqValid = 4'b1111;
        #1;
        checks++; if (myGrant !== 4'b0000) begin fails++; $display("FAIL midrst_idle: got %b want 0000", myGrant); end
        advance();
        #1;
        checks++; if (myGrant !== 4'b0001) begin fails++; $display("FAIL midrst_regrant: got %b want 0001", myGrant); end
        myReqValid = '0;
    endtask

    task automatic test_fifo_integration();
        logic       w;
        logic [7:0] d;
        logic [7:0] got;
        int         cyc;
        do_reset();
        fifoQ.delete();
        cyc = 0;
        while ((fifoQ.size() < 16) && (cyc < 60)) begin
            myWfull = (fifoQ.size() >= 16);
            for (int i = 0; i < NR; i++) myReqValid[i] = (prodCnt[i] < 4);
            #1;
            checks++; if (myWfull && myWreq) begin fails++; $display("FAIL fifo_write_when_full c%0d: wreq %b full %b", cyc, myWreq, myWfull); end
            w = myWreq;
            d = myWdata;
            advance();
            if (w) fifoQ.push_back(d);
            cyc++;
        end
        checks++; if (fifoQ.size() != 16) begin fails++; $display("FAIL fifo_fill_timeout: got %0d words want 16", fifoQ.size()); end
        myReqValid = 4'b0001;
        for (int c = 0; c < 6; c++) begin
            myWfull = (fifoQ.size() >= 16);
            #1;
            checks++; if (myWreq !== 1'b0) begin fails++; $display("FAIL fifo_full_wreq c%0d: got %b want 0", c, myWreq); end
            checks++; if (myReqReady !== 4'b0000) begin fails++; $display("FAIL fifo_full_ready c%0d: got %b want 0000", c, myReqReady); end
            if (myWreq) fifoQ.push_back(myWdata);
            advance();
        end
        myReqValid = '0;
        advance();
        myWfull = 1'b0;
        #1;
        checks++; if (myWordCnt !== 16'd16) begin fails++; $display("FAIL fifo_wordcnt: got %0d want 16", myWordCnt); end
        for (int k = 0; k < 16; k++) begin
            got = (fifoQ.size() > 0) ? fifoQ.pop_front() : 8'hxx;
            checks++; if (got !== 8'((k / 4) * 16 + (k % 4) + 1)) begin fails++; $display("FAIL fifo_order k%0d: got %0d want %0d", k, got, (k / 4) * 16 + (k % 4) + 1); end
        end
    endtask

    // Reference model: owner (-1 when idle), last granted index, words in the
    // current burst and total words written.
    task automatic test_random();
        int            mOwner, mLast, mBurst, mCount;
        logic [NR-1:0] vSnap;
        logic [3:0]    eG, eR;
        logic          eAcc;
        logic [7:0]    eD;
        do_reset();
        mOwner = -1;
        mLast  = NR - 1;
        mBurst = 0;
        mCount = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) if ($urandom_range(0, 99) < 15) myReqValid[i] = ~myReqValid[i];
            myReqData = $urandom;
            myWfull   = ($urandom_range(0, 99) < 20);
            #1;
            vSnap = myReqValid;
            eAcc  = (mOwner >= 0) && vSnap[mOwner] && !myWfull;
            eG    = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
            eR    = eAcc ? eG : 4'b0000;
            eD    = (mOwner >= 0) ? myReqData[mOwner*DW +: DW] : 8'h00;
            checks++; if (myGrant !== eG) begin fails++; $display("FAIL rnd_grant c%0d: got %b want %b", c, myGrant, eG); end
            checks++; if (myReqReady !== eR) begin fails++; $display("FAIL rnd_ready c%0d: got %b want %b", c, myReqReady, eR); end
            checks++; if (myWreq !== eAcc) begin fails++; $display("FAIL rnd_wreq c%0d: got %b want %b", c, myWreq, eAcc); end
            checks++; if (myWdata !== eD) begin fails++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, myWdata, eD); end
            checks++; if (myWordCnt !== 16'(mCount)) begin fails++; $display("FAIL rnd_wordcnt c%0d: got %0d want %0d", c, myWordCnt, mCount); end
            advance();
            if (mOwner < 0) begin
                for (int k = 1; k <= NR; k++) begin
                    if ((mOwner < 0) && vSnap[(mLast + k) % NR]) mOwner = (mLast + k) % NR;
                end
                if (mOwner >= 0) begin
                    mLast  = mOwner;
                    mBurst = 0;
                end
            end else begin
                if (eAcc) begin
                    mCount = (mCount + 1) % 65536;
                    mBurst++;
                end
                if (!vSnap[mOwner] || (mBurst == MB)) mOwner = -1;
            end
        end
        myReqValid = '0;
        myWfull    = 1'b0;
    endtask

    initial begin
        myRst      = 1'b1;
        myReqValid = '0;
        myWfull    = 1'b0;
        myReqData  = '0;
        test_reset();
        test_single_requester();
        test_round_robin();
        test_full_stall();
        test_early_withdraw();
        test_reset_mid_burst();
        test_fifo_integration();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
